bin_to_bcd_seq: RTL

//  Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin_to_bcd_seq.sv | 84 ++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encodings, digit width, add-3 constants and a bench helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  // Largest decimal value representable with the given number of digits.
  function automatic int max_dec(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= DIGIT_W'(ADJ_THRESH)) ? digit + DIGIT_W'(ADJ_ADD) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock,
// with a start/busy/done handshake and held BCD/overflow result registers.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [WIDTH-1:0]        BIN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [DIGIT_W*DIGITS-1:0] BCD,
  output logic                    OVF
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t            state_reg;
  logic [SR_W-1:0]   sr_reg;
  logic [SR_W-1:0]   sr_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ovf_acc_reg;
  logic [BCD_W-1:0]  adj;
  logic              ovf_bit;

  // Working digits sit above the not-yet-consumed binary bits.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (sr_reg[WIDTH + DIGIT_W*gi +: DIGIT_W]),
      .adjusted (adj[DIGIT_W*gi +: DIGIT_W])
    );
  end

  // The bit shifted out of the top digit marks a value beyond DIGITS digits.
  assign ovf_bit = adj[BCD_W-1];
  assign sr_next = {adj[BCD_W-2:0], sr_reg[WIDTH-1:0], 1'b0};

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      sr_reg      <= '0;
      cnt_reg     <= '0;
      ovf_acc_reg <= 1'b0;
      BCD         <= '0;
      OVF         <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            sr_reg      <= {{BCD_W{1'b0}}, BIN};
            cnt_reg     <= CNT_W'(WIDTH);
            ovf_acc_reg <= 1'b0;
            BUSY        <= 1'b1;
            state_reg   <= ST_SHIFT;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sr_reg      <= sr_next;
          cnt_reg     <= cnt_reg - CNT_W'(1);
          ovf_acc_reg <= ovf_acc_reg | ovf_bit;
          if (cnt_reg == CNT_W'(1)) begin
            BCD       <= sr_next[SR_W-1 -: BCD_W];
            OVF       <= ovf_acc_reg | ovf_bit;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
